// File: rtl/fdiv_pkg.sv
// Shared types and helpers for the programmable fractional clock divider.
package fdiv_pkg;

  localparam int DIV_X2_MIN = 4;
  localparam int DIV_W_MAX  = 16;

  // Wide carrier for the div field; each user narrows it to its own DIV_W.
  typedef logic [DIV_W_MAX-1:0] div_wide_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } run_state_t;

  function automatic div_wide_t fdiv_clamp(div_wide_t v, bit half_en);
    div_wide_t r;
    r = v;
    if (!half_en) r[0] = 1'b0;
    if (r < div_wide_t'(DIV_X2_MIN)) r = div_wide_t'(DIV_X2_MIN);
    return r;
  endfunction

endpackage

// File: rtl/fdiv_frac_prog_if.sv
// Control/status bundle of the fractional clock divider.
interface fdiv_frac_prog_if #(
  parameter int DIV_W = 8
);
  logic             en;
  logic [DIV_W-1:0] div_x2;
  logic             clk_out;
  logic             tick;
  logic             running;
  logic [DIV_W-1:0] div_cur;

  modport master (
    output en, div_x2,
    input  clk_out, tick, running, div_cur
  );

  modport slave (
    input  en, div_x2,
    output clk_out, tick, running, div_cur
  );
endinterface

// File: rtl/fdiv_edge_gen.sv
// Output stage: posedge flop P and, with FDIV_HALF_EN, negedge flop N; clk_out = P & N.
// clk only clocks the flops, it never reaches the output path.
module fdiv_edge_gen (
  input  logic clk,
  input  logic clr,
  input  logic p_en,
`ifdef FDIV_HALF_EN
  input  logic n_en,
`endif
  output logic clk_out
);

  logic p_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) p_q <= 1'b0;
    else     p_q <= p_en;
  end

`ifdef FDIV_HALF_EN
  logic n_q;

  always_ff @(negedge clk or posedge clr) begin
    if (clr) n_q <= 1'b0;
    else     n_q <= n_en;
  end

  assign clk_out = p_q & n_q;
`else
  assign clk_out = p_q;
`endif

endmodule

// File: rtl/fdiv_frac_prog.sv
// Runtime-programmable divider, clk_out = clk / (div_x2/2), frame = div_x2 clk cycles.
// Half-integer ratios (negedge flop) are built only when FDIV_HALF_EN is defined.
module fdiv_frac_prog
  import fdiv_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int DIV_RST = 9
) (
  input logic             clk,
  input logic             clr,
  fdiv_frac_prog_if.slave bus
);

`ifdef FDIV_HALF_EN
  localparam bit HALF_EN = 1'b1;
`else
  localparam bit HALF_EN = 1'b0;
`endif
  localparam int HW = DIV_W + 2;

  typedef logic [DIV_W-1:0] div_t;
  typedef logic [HW-1:0]    half_t;

  localparam div_t DIV_RST_C = div_t'(fdiv_clamp(div_wide_t'(DIV_RST), HALF_EN));

  function automatic div_t clamp_div(div_t v);
    return div_t'(fdiv_clamp(div_wide_t'(v), HALF_EN));
  endfunction

  // True when half-cycle h of a frame (0 <= h < 2d) lies in a high segment.
  function automatic logic in_high(half_t h, div_t d);
    half_t dd;
    half_t hm;
    dd = half_t'(d);
    hm = (h >= dd) ? h - dd : h;
    return hm < (dd >> 1);
  endfunction

  run_state_t state, state_nxt;
  div_t       cnt, cnt_nxt;
  div_t       div_cur, div_nxt;
  logic       last, boundary;
  logic       running, tick;
  logic       p_en, clk_div;

  assign last     = (state == ST_RUN) && (cnt == div_cur - div_t'(1));
  assign boundary = (state != ST_RUN) || last;
  assign div_nxt  = boundary ? clamp_div(bus.div_x2) : div_cur;
  assign cnt_nxt  = (state == ST_RUN && !last) ? cnt + div_t'(1) : '0;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // ARM is the one-cycle gap between sampling en while idle and frame start.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.en) state_nxt = ST_ARM;
      ST_ARM:  state_nxt = ST_RUN;
      ST_RUN:  if (last && !bus.en) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    running = (state == ST_RUN);
    tick    = (state == ST_RUN) && (cnt == '0);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt     <= '0;
      div_cur <= DIV_RST_C;
    end else begin
      cnt     <= cnt_nxt;
      div_cur <= div_nxt;
    end
  end

  // P holds for the posedge slot {2c, 2c+1} of the cycle being entered.
  assign p_en = (state_nxt == ST_RUN) &&
                (in_high({1'b0, cnt_nxt, 1'b0}, div_nxt) ||
                 in_high({1'b0, cnt_nxt, 1'b1}, div_nxt));

`ifdef FDIV_HALF_EN
  logic  n_en;
  half_t h_neg;

  // N holds for the negedge slot {2c+1, 2c+2}; in the last slot it is raised
  // speculatively for the next frame's first half-cycle, harmless if P stays low.
  assign h_neg = {1'b0, cnt, 1'b1};
  assign n_en  = (state == ST_ARM) ||
                 (running && (last || in_high(h_neg, div_cur) ||
                              in_high(h_neg + half_t'(1), div_cur)));

  fdiv_edge_gen u_edge (
    .clk     (clk),
    .clr     (clr),
    .p_en    (p_en),
    .n_en    (n_en),
    .clk_out (clk_div)
  );
`else
  fdiv_edge_gen u_edge (
    .clk     (clk),
    .clr     (clr),
    .p_en    (p_en),
    .clk_out (clk_div)
  );
`endif

  assign bus.clk_out = clk_div;
  assign bus.tick    = tick;
  assign bus.running = running;
  assign bus.div_cur = div_cur;

endmodule

// File: tb/tb_fdiv_frac_prog.sv
// Scoreboard bench for fdiv_frac_prog: stimulus queues one expected divisor per frame,
// a monitor checks each frame against a half-cycle waveform model.
module tb_fdiv_frac_prog;

  localparam int HALF = 5;

  logic clk = 1'b0;
  logic clr = 1'b1;

  int  n_checks = 0;
  int  n_errors = 0;
  int  exp_q[$];

  bit  in_frame = 1'b0;
  int  h = 0;
  int  d_frame = 4;
  int  werr = 0;
  int  idle_err = 0;
  int  run_err = 0;
  int  glitch_err = 0;
  time last_t = 0;
  bit  g_valid = 1'b0;

  fdiv_frac_prog_if #(.DIV_W(8)) bus ();

  fdiv_frac_prog #(.DIV_W(8), .DIV_RST(9)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #HALF clk = ~clk;

  function automatic int eff(int v);
    int r;
    r = v;
`ifndef FDIV_HALF_EN
    r = r & ~1;
`endif
    if (r < 4) r = 4;
    return r;
  endfunction

  // Expected clk_out at half-cycle hh of a frame with divisor d.
  function automatic bit model_hi(int hh, int d);
    int x;
    x = hh;
`ifndef FDIV_HALF_EN
    x = x & ~1;
`endif
    return (x % d) < (d / 2);
  endfunction

  function automatic void chk(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void close_frame();
    chk("wave", werr, 0);
    werr = 0;
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drain(int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic push(int d, int n);
    for (int i = 0; i < n; i++) exp_q.push_back(d);
  endtask

  // Monitor: samples 1 time unit after every clk edge.
  initial begin : monitor
    bit e;
    forever begin
      @(clk);
      #1;
      if (clr) begin
        if (in_frame) close_frame();
        in_frame = 1'b0;
      end else begin
        if (in_frame) h++;
        if (clk && bus.tick) begin
          if (in_frame) begin
            chk("tick_spacing", h, 2 * d_frame);
            close_frame();
          end
          chk("sb_pending", (exp_q.size() > 0) ? 1 : 0, 1);
          if (exp_q.size() > 0) begin
            d_frame = exp_q.pop_front();
            chk("div_cur", int'(bus.div_cur), d_frame);
            in_frame = 1'b1;
            h = 0;
            werr = 0;
          end
        end else if (in_frame && h >= 2 * d_frame) begin
          close_frame();
          in_frame = 1'b0;
        end
        e = in_frame ? model_hi(h, d_frame) : 1'b0;
        if (bus.clk_out !== e) begin
          if (in_frame) werr++;
          else idle_err++;
        end
        if (bus.running !== in_frame) run_err++;
      end
    end
  end

  always @(bus.clk_out) begin
    if (!clr && g_valid && ($time - last_t) < HALF) glitch_err++;
    last_t  = $time;
    g_valid = !clr;
  end

  initial begin : stim
    int d9, d6, d8, d11;
    d9  = eff(9);
    d6  = eff(6);
    d8  = eff(8);
    d11 = eff(11);
    bus.en     = 1'b0;
    bus.div_x2 = 8'd9;

    #12;
    chk("rst_clk_out", int'(bus.clk_out), 0);
    chk("rst_tick",    int'(bus.tick),    0);
    chk("rst_running", int'(bus.running), 0);
    chk("rst_div_cur", int'(bus.div_cur), eff(9));

    // Start-up: first frame start on the 2nd posedge after clr release.
    bus.en = 1'b1;
    push(d9, 3);
    #10 clr = 1'b0;
    step(1);
    chk("startup_p1_running", int'(bus.running), 0);
    chk("startup_p1_tick",    int'(bus.tick),    0);
    step(1);
    chk("startup_f_running",  int'(bus.running), 1);
    chk("startup_f_tick",     int'(bus.tick),    1);
    drain(200);

    // Mid-frame divisor change at cnt=3 only takes effect at the wrap.
    step(3);
    bus.div_x2 = 8'd6;
    push(d6, 3);
    step(1);
    chk("div_hold_mid", int'(bus.div_cur), d9);
    step(d9 - 1 - 4);
    chk("div_hold_end", int'(bus.div_cur), d9);
    step(1);
    chk("div_new_at_wrap", int'(bus.div_cur), d6);
    drain(200);

    bus.div_x2 = 8'd8;
    push(d8, 2);
    drain(200);

    // Clamp of small values and the widest divisor.
    bus.div_x2 = 8'd3;
    push(4, 2);
    drain(200);
    bus.div_x2 = 8'd0;
    push(4, 2);
    drain(200);
    bus.div_x2 = 8'd255;
    push(eff(255), 1);
    drain(600);

    bus.div_x2 = 8'd9;
    push(d9, 1);
    drain(600);

    // Stop with a simultaneous divisor change, then restart.
    step(2);
    bus.en     = 1'b0;
    bus.div_x2 = 8'd8;
    step(d9 - 1 - 2);
    chk("stop_last_running", int'(bus.running), 1);
    step(1);
    chk("stop_running",  int'(bus.running), 0);
    chk("stop_tick",     int'(bus.tick),    0);
    chk("stop_div_cur",  int'(bus.div_cur), d8);
    step(4);
    chk("idle_clk_out",  int'(bus.clk_out), 0);
    chk("idle_running",  int'(bus.running), 0);
    bus.en = 1'b1;
    push(d8, 2);
    step(1);
    chk("restart_p1_running", int'(bus.running), 0);
    step(1);
    chk("restart_f_tick",     int'(bus.tick),    1);
    chk("restart_f_running",  int'(bus.running), 1);
    drain(200);

    // clr while high in a period that begins mid-cycle.
    bus.div_x2 = 8'd11;
    push(d11, 1);
    drain(200);
    step(5);
    @(negedge clk);
    #2;
    chk("pre_clr_high", int'(bus.clk_out), 1);
    clr = 1'b1;
    #1;
    chk("clr_clk_out", int'(bus.clk_out), 0);
    chk("clr_tick",    int'(bus.tick),    0);
    chk("clr_running", int'(bus.running), 0);
    chk("clr_div_cur", int'(bus.div_cur), eff(9));
    step(2);
    push(d11, 1);
    clr = 1'b0;
    step(1);
    chk("clr_restart_p1_running", int'(bus.running), 0);
    step(1);
    chk("clr_restart_f_tick", int'(bus.tick), 1);
    drain(50);
    bus.en = 1'b0;
    step(d11);
    chk("final_stop_running", int'(bus.running), 0);
    step(3);

    chk("idle_low",       idle_err,   0);
    chk("running_track",  run_err,    0);
    chk("min_pulse",      glitch_err, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
